// File: rtl/orv64_itb_ctrl_if.sv
// Trace-record input and ITB RAM normal-port bundle for the trace buffer controller.
// The controller takes the slave side; the pipeline/RAM environment takes the master side.
interface orv64_itb_ctrl_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_cf;
    logic              itb_dbg_en;
    logic              itb_en;
    logic [DATA_W-1:0] itb_data;
    logic [ADDR_W-1:0] itb_addr;

    modport master (
        output in_valid, in_data, in_cf, itb_dbg_en,
        input  itb_en, itb_data, itb_addr
    );

    modport slave (
        input  in_valid, in_data, in_cf, itb_dbg_en,
        output itb_en, itb_data, itb_addr
    );
endinterface

// File: rtl/orv64_itb_ctrl.sv
// Capture-side controller for the orv64 instruction trace buffer: filters retired records,
// writes them circularly into the ITB RAM, and freezes after a trigger plus post window.
module orv64_itb_ctrl #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    orv64_itb_ctrl_if.slave   bus,
    input  logic              cfg_en,
    input  logic              cfg_cf_only,
    input  logic              cfg_trig_en,
    input  logic [DATA_W-1:0] cfg_trig_val,
    input  logic [DATA_W-1:0] cfg_trig_mask,
    input  logic [ADDR_W-1:0] cfg_post_cnt,
    input  logic              dbg_clear,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              wrapped,
    output logic              frozen,
    output logic [ADDR_W-1:0] trig_addr,
    output logic              drop
);
    typedef enum logic [1:0] {IDLE, CAPTURE, POST, FROZEN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wrapped_q, wrapped_d;
    logic              drop_q, drop_d;
    logic              itb_en_q, itb_en_d;
    logic [DATA_W-1:0] itb_data_q, itb_data_d;
    logic [ADDR_W-1:0] itb_addr_q, itb_addr_d;

    logic eligible, accept, collide, hit;

    // A record that would have been accepted but meets an active debug port is lost, not retried.
    always_comb begin
        eligible = bus.in_valid & (~cfg_cf_only | bus.in_cf) &
                   ((state_q == CAPTURE) | (state_q == POST));
        accept   = eligible & ~bus.itb_dbg_en;
        collide  = eligible & bus.itb_dbg_en;
        hit      = accept & cfg_trig_en &
                   (((bus.in_data ^ cfg_trig_val) & cfg_trig_mask) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            trig_addr_q <= '0;
            cnt_q       <= '0;
            wrapped_q   <= 1'b0;
            drop_q      <= 1'b0;
            itb_en_q    <= 1'b0;
            itb_data_q  <= '0;
            itb_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            trig_addr_q <= trig_addr_d;
            cnt_q       <= cnt_d;
            wrapped_q   <= wrapped_d;
            drop_q      <= drop_d;
            itb_en_q    <= itb_en_d;
            itb_data_q  <= itb_data_d;
            itb_addr_q  <= itb_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        trig_addr_d = trig_addr_q;
        cnt_d       = cnt_q;
        wrapped_d   = wrapped_q;
        drop_d      = drop_q;
        itb_en_d    = 1'b0;
        itb_data_d  = itb_data_q;
        itb_addr_d  = itb_addr_q;

        if (dbg_clear) begin
            wr_ptr_d    = '0;
            trig_addr_d = '0;
            cnt_d       = '0;
            wrapped_d   = 1'b0;
            drop_d      = 1'b0;
            state_d     = cfg_en ? CAPTURE : IDLE;
        end else begin
            if (accept) begin
                itb_en_d   = 1'b1;
                itb_data_d = bus.in_data;
                itb_addr_d = wr_ptr_q;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                if (wr_ptr_q == '1)
                    wrapped_d = 1'b1;
            end
            if (collide)
                drop_d = 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (cfg_en) begin
                        state_d     = CAPTURE;
                        wr_ptr_d    = '0;
                        wrapped_d   = 1'b0;
                        drop_d      = 1'b0;
                        trig_addr_d = '0;
                    end
                end
                CAPTURE: begin
                    if (hit) begin
                        trig_addr_d = wr_ptr_q;
                        if (cfg_post_cnt == '0) begin
                            state_d = FROZEN;
                        end else begin
                            cnt_d   = cfg_post_cnt;
                            state_d = POST;
                        end
                    end
                end
                POST: begin
                    if (accept) begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q <= ADDR_W'(1))
                            state_d = FROZEN;
                    end
                end
                FROZEN: ;
                default: state_d = IDLE;
            endcase

            // Disabling capture parks in IDLE but keeps pointer and flags for readout.
            if (!cfg_en && state_q != IDLE)
                state_d = IDLE;
        end
    end

    always_comb begin
        bus.itb_en   = itb_en_q;
        bus.itb_data = itb_data_q;
        bus.itb_addr = itb_addr_q;
        wr_ptr       = wr_ptr_q;
        wrapped      = wrapped_q;
        frozen       = (state_q == FROZEN);
        trig_addr    = trig_addr_q;
        drop         = drop_q;
    end
endmodule
